sram_bist_ctrl: RTL and testbench

//   March C- built-in self-test initiator for the single-port RW0 interface of the SRAM wrapper.

---
 rtl/sram_bist_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_sram_bist_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bist_ctrl.sv
// March C- BIST initiator for the single-port RW0 SRAM wrapper interface.
// Optional second checkerboard pass: define SRAM_BIST_CHECKERBOARD_EN.
module sram_bist_ctrl #(
   parameter int unsigned ADDR_W = 4,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_syn,
   output logic [7:0]        err_cnt,
   output logic [ADDR_W-1:0] RW0_addr,
   output logic [DATA_W-1:0] RW0_wdata,
   output logic              RW0_en,
   output logic              RW0_wmode,
   input  logic [DATA_W-1:0] RW0_rdata
);

   localparam int unsigned DCNT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
   localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

   typedef enum logic [1:0] {IDLE, MARCH, DRAIN, DONE} state_t;

   state_t              state;
   logic [2:0]          elem;
   logic [ADDR_W-1:0]   addr_q;
   logic                phase;
   logic [DCNT_W-1:0]   dcnt;

   logic                pipe_v [RD_LAT];
   logic [ADDR_W-1:0]   pipe_a [RD_LAT];
   logic [DATA_W-1:0]   pipe_e [RD_LAT];

   logic [DATA_W-1:0]   bg_c;
   logic                last_pass_c;
   logic                down_c;
   logic                op_wr_c;
   logic                addr_done_c;
   logic                addr_end_c;
   logic                last_op_c;
   logic [ADDR_W-1:0]   addr_nxt_c;
   logic [DATA_W-1:0]   op_data_c;
   logic [DATA_W-1:0]   syn_c;
   logic                mis_c;
   logic [7:0]          err_nxt_c;

`ifdef SRAM_BIST_CHECKERBOARD_EN
   logic ckb_q;

   // Pass index: 0 = solid background, 1 = checkerboard background
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ckb_q <= 1'b0;
      end else if ((state == IDLE || state == DONE) && start) begin
         ckb_q <= 1'b0;
      end else if (state == MARCH && addr_done_c && addr_end_c && elem == 3'd5) begin
         ckb_q <= 1'b1;
      end
   end

   assign bg_c        = ckb_q ? ({(DATA_W/2){2'b01}} ^ {DATA_W{addr_q[0]}}) : '0;
   assign last_pass_c = ckb_q;
`else
   assign bg_c        = '0;
   assign last_pass_c = 1'b1;
`endif

   // Current march operation decoded from element, address and r/w phase
   always_comb begin
      down_c      = (elem == 3'd3) || (elem == 3'd4);
      op_wr_c     = (elem == 3'd0) || ((elem != 3'd5) && phase);
      addr_done_c = (elem == 3'd0) || (elem == 3'd5) || phase;
      addr_end_c  = down_c ? (addr_q == '0) : (addr_q == ADDR_LAST);
      last_op_c   = (elem == 3'd5) && addr_end_c && last_pass_c;
      if (op_wr_c) begin
         op_data_c = ((elem == 3'd1) || (elem == 3'd3)) ? ~bg_c : bg_c;
      end else begin
         op_data_c = ((elem == 3'd2) || (elem == 3'd4)) ? ~bg_c : bg_c;
      end
      // E2->E3 and E4->E5 start on the address where the previous element ended
      if (addr_end_c && ((elem == 3'd2) || (elem == 3'd4))) begin
         addr_nxt_c = addr_q;
      end else if (down_c) begin
         addr_nxt_c = addr_q - ADDR_W'(1);
      end else begin
         addr_nxt_c = addr_q + ADDR_W'(1);
      end
   end

   // Compare stage at the pipe output
   always_comb begin
      syn_c     = RW0_rdata ^ pipe_e[RD_LAT-1];
      mis_c     = pipe_v[RD_LAT-1] && (syn_c != '0) && ((state == MARCH) || (state == DRAIN));
      err_nxt_c = (mis_c && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;
   end

   // Expected read data travels on RW0_wdata, so the pipe taps the registered port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(RD_LAT); i++) begin
            pipe_v[i] <= 1'b0;
            pipe_a[i] <= '0;
            pipe_e[i] <= '0;
         end
      end else begin
         pipe_v[0] <= RW0_en && !RW0_wmode;
         pipe_a[0] <= RW0_addr;
         pipe_e[0] <= RW0_wdata;
         for (int i = 1; i < int'(RD_LAT); i++) begin
            pipe_v[i] <= pipe_v[i-1];
            pipe_a[i] <= pipe_a[i-1];
            pipe_e[i] <= pipe_e[i-1];
         end
      end
   end

   // Control FSM with registered status and SRAM port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         elem      <= '0;
         addr_q    <= '0;
         phase     <= 1'b0;
         dcnt      <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_addr <= '0;
         fail_syn  <= '0;
         err_cnt   <= '0;
         RW0_addr  <= '0;
         RW0_wdata <= '0;
         RW0_en    <= 1'b0;
         RW0_wmode <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state     <= MARCH;
                  elem      <= '0;
                  addr_q    <= '0;
                  phase     <= 1'b0;
                  done      <= 1'b0;
                  pass      <= 1'b0;
                  fail_addr <= '0;
                  fail_syn  <= '0;
                  err_cnt   <= '0;
               end
            end
            MARCH: begin
               busy      <= 1'b1;
               RW0_en    <= 1'b1;
               RW0_wmode <= op_wr_c;
               RW0_addr  <= addr_q;
               RW0_wdata <= op_data_c;
               if (last_op_c) begin
                  state <= DRAIN;
                  dcnt  <= '0;
               end else begin
                  phase <= ((elem == 3'd0) || (elem == 3'd5)) ? 1'b0 : ~phase;
                  if (addr_done_c) begin
                     addr_q <= addr_nxt_c;
                     if (addr_end_c) begin
                        elem <= (elem == 3'd5) ? 3'd0 : elem + 3'd1;
                     end
                  end
               end
            end
            DRAIN: begin
               RW0_en    <= 1'b0;
               RW0_wmode <= 1'b0;
               RW0_addr  <= '0;
               RW0_wdata <= '0;
               if (dcnt == DCNT_W'(RD_LAT)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_nxt_c == 8'd0);
               end else begin
                  dcnt <= dcnt + DCNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase

         if (mis_c) begin
            err_cnt <= err_nxt_c;
            if (err_cnt == 8'd0) begin
               fail_addr <= pipe_a[RD_LAT-1];
               fail_syn  <= syn_c;
            end
         end
      end
   end

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Self-checking bench for sram_bist_ctrl: SRAM wrapper model with injectable faults
// and an abstract March C- reference model.
module tb_sram_bist_ctrl;

   localparam int unsigned ADDR_W = 4;
   localparam int unsigned DATA_W = 16;
   localparam int unsigned RD_LAT = 2;
   localparam int unsigned WORDS  = 16;
`ifdef SRAM_BIST_CHECKERBOARD_EN
   localparam int unsigned PASSES = 2;
`else
   localparam int unsigned PASSES = 1;
`endif
   localparam int unsigned OPS = 10 * WORDS * PASSES;

   typedef struct packed {
      logic              w;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
   } op_t;

   typedef struct {
      int kind;
      int fa;
      int fb;
      int pulse_at;
      int e_pass;
      int e_err;
      int e_faddr;
      int e_fsyn;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              start;
   logic              busy, done, pass;
   logic [ADDR_W-1:0] fail_addr;
   logic [DATA_W-1:0] fail_syn;
   logic [7:0]        err_cnt;
   logic [ADDR_W-1:0] RW0_addr;
   logic [DATA_W-1:0] RW0_wdata;
   logic              RW0_en, RW0_wmode;
   logic [DATA_W-1:0] RW0_rdata;

   int checks = 0;
   int errors = 0;

   int f_kind = 0, f_addr = 0, f_bit = 0;
   logic [DATA_W-1:0] mem [WORDS];
   logic [DATA_W-1:0] rd_pipe [RD_LAT];

   op_t exp_ops[$];
   op_t got_ops[$];
   int  m_errs, m_faddr, m_fsyn;
   int  r_lat, r_busy, r_en;
   bit  r_fin;

   sram_bist_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .busy(busy), .done(done), .pass(pass),
      .fail_addr(fail_addr), .fail_syn(fail_syn), .err_cnt(err_cnt),
      .RW0_addr(RW0_addr), .RW0_wdata(RW0_wdata), .RW0_en(RW0_en),
      .RW0_wmode(RW0_wmode), .RW0_rdata(RW0_rdata)
   );

   always #5 clk = ~clk;

   // Fault kinds: 0 none, 1 stuck-at-1, 2 stuck-at-0, 3 every read inverted
   function automatic logic [DATA_W-1:0] apply_fault(input logic [DATA_W-1:0] d, input int a,
                                                     input int kind, input int fa, input int fb);
      logic [DATA_W-1:0] m;
      m = DATA_W'(1) << fb;
      case (kind)
         1: return (a == fa) ? (d | m) : d;
         2: return (a == fa) ? (d & ~m) : d;
         3: return ~d;
         default: return d;
      endcase
   endfunction

   // SRAM wrapper: read data valid RD_LAT cycles after the issue cycle
   always @(posedge clk) begin
      if (RW0_en && RW0_wmode) mem[RW0_addr] <= RW0_wdata;
      rd_pipe[0] <= (RW0_en && !RW0_wmode) ?
                    apply_fault(mem[RW0_addr], int'(RW0_addr), f_kind, f_addr, f_bit) :
                    DATA_W'($urandom);
      for (int i = 1; i < int'(RD_LAT); i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign RW0_rdata = rd_pipe[RD_LAT-1];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   // Reference: walk the March C- algorithm over an array, no timing
   task automatic march_model(input int kind, input int fa, input int fb);
      logic [DATA_W-1:0] m [WORDS];
      logic [DATA_W-1:0] d0, ex, got;
      int rd_sel [6];
      int wr_sel [6];
      int dn [6];
      int a;
      op_t o;
      rd_sel = '{-1, 0, 1, 0, 1, 0};
      wr_sel = '{0, 1, 0, 1, 0, -1};
      dn     = '{0, 0, 0, 1, 1, 0};
      exp_ops.delete();
      m_errs = 0; m_faddr = 0; m_fsyn = 0;
      for (int p = 0; p < int'(PASSES); p++)
         for (int e = 0; e < 6; e++)
            for (int i = 0; i < int'(WORDS); i++) begin
               a  = (dn[e] != 0) ? int'(WORDS) - 1 - i : i;
               d0 = (p == 0) ? 16'h0000 : ((a % 2 == 1) ? 16'hAAAA : 16'h5555);
               if (rd_sel[e] >= 0) begin
                  ex  = (rd_sel[e] == 1) ? ~d0 : d0;
                  got = apply_fault(m[a], a, kind, fa, fb);
                  if (got != ex) begin
                     if (m_errs == 0) begin m_faddr = a; m_fsyn = int'(got ^ ex); end
                     if (m_errs < 255) m_errs++;
                  end
                  o.w = 1'b0; o.a = ADDR_W'(a); o.d = '0;
                  exp_ops.push_back(o);
               end
               if (wr_sel[e] >= 0) begin
                  m[a] = (wr_sel[e] == 1) ? ~d0 : d0;
                  o.w = 1'b1; o.a = ADDR_W'(a); o.d = m[a];
                  exp_ops.push_back(o);
               end
            end
   endtask

   // Launch a run from IDLE/DONE and record it until done (bounded)
   task automatic do_run(input int pulse_at, input string tag);
      op_t o;
      int  j;
      got_ops.delete();
      r_busy = 0; r_en = 0; r_fin = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk({tag, "_clr_done"}, 64'(done), 64'd0);
      chk({tag, "_clr_err"}, 64'({pass, err_cnt, fail_addr, fail_syn}), 64'd0);
      j = 0;
      while (j < int'(OPS) + 50) begin
         if (done) begin r_fin = 1; break; end
         if (busy) r_busy++;
         if (RW0_en) begin
            r_en++;
            o.w = RW0_wmode; o.a = RW0_addr; o.d = RW0_wmode ? RW0_wdata : '0;
            got_ops.push_back(o);
         end
         start = (j == pulse_at);
         @(negedge clk); j++;
      end
      start = 1'b0;
      r_lat = j;
      chk({tag, "_done_timeout"}, 64'(r_fin), 64'd1);
   endtask

   task automatic check_run(input string tag, input int e_pass, input int e_err,
                            input int e_faddr, input int e_fsyn);
      int bad;
      chk({tag, "_done_lat"}, 64'(r_lat), 64'(OPS + RD_LAT + 1));
      chk({tag, "_busy_cyc"}, 64'(r_busy), 64'(OPS + RD_LAT));
      chk({tag, "_accesses"}, 64'(r_en), 64'(OPS));
      chk({tag, "_pass"}, 64'(pass), 64'(e_pass));
      chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(e_err));
      chk({tag, "_fail_addr"}, 64'(fail_addr), 64'(e_faddr));
      chk({tag, "_fail_syn"}, 64'(fail_syn), 64'(e_fsyn));
      bad = 0;
      if (got_ops.size() != exp_ops.size()) bad = 1000;
      else foreach (got_ops[k]) if (got_ops[k] != exp_ops[k]) bad++;
      chk({tag, "_op_stream"}, 64'(bad), 64'd0);
   endtask

   vec_t vecs [4];

   initial begin
      vecs[0] = '{kind:1, fa:5, fb:3, pulse_at:40, e_pass:0, e_err:3 + 2*(int'(PASSES)-1), e_faddr:5, e_fsyn:'h0008};
      vecs[1] = '{kind:3, fa:0, fb:0, pulse_at:-1, e_pass:0, e_err:80*int'(PASSES), e_faddr:0, e_fsyn:'hFFFF};
      vecs[2] = '{kind:0, fa:0, fb:0, pulse_at:-1, e_pass:1, e_err:0, e_faddr:0, e_fsyn:0};
      vecs[3] = '{kind:2, fa:2, fb:0, pulse_at:-1, e_pass:0, e_err:2 + 3*(int'(PASSES)-1), e_faddr:2, e_fsyn:'h0001};

      start = 1'b0;
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_status", 64'({busy, done, pass, err_cnt, fail_addr, fail_syn}), 64'd0);
      chk("rst_port", 64'({RW0_en, RW0_wmode, RW0_addr, RW0_wdata}), 64'd0);
      rst_n = 1'b1;
      begin
         int act;
         act = 0;
         repeat (10) begin
            @(negedge clk);
            if (RW0_en || busy || done) act++;
         end
         chk("idle_no_activity", 64'(act), 64'd0);
      end

      // Directed vectors; the first also pulses start mid-run, later ones start from DONE
      for (int i = 0; i < 4; i++) begin
         string tag;
         tag = $sformatf("vec%0d", i);
         f_kind = vecs[i].kind; f_addr = vecs[i].fa; f_bit = vecs[i].fb;
         march_model(f_kind, f_addr, f_bit);
         do_run(vecs[i].pulse_at, tag);
         check_run(tag, vecs[i].e_pass, vecs[i].e_err, vecs[i].e_faddr, vecs[i].e_fsyn);
`ifdef SRAM_BIST_CHECKERBOARD_EN
         if (vecs[i].kind == 0 && got_ops.size() > int'(OPS/2) + 1) begin
            chk("ckb_first_w_a0", 64'(got_ops[OPS/2]), 64'({1'b1, 4'd0, 16'h5555}));
            chk("ckb_first_w_a1", 64'(got_ops[OPS/2+1]), 64'({1'b1, 4'd1, 16'hAAAA}));
         end
`endif
      end

      // Reset mid-run with an error already latched
      f_kind = 1; f_addr = 5; f_bit = 3;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (80) @(negedge clk);
      chk("pre_rst_err_seen", 64'(err_cnt), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("midrst_en_busy", 64'({RW0_en, busy}), 64'd0);
      chk("midrst_status", 64'({done, pass, err_cnt, fail_addr, fail_syn}), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      f_kind = 0;
      march_model(0, 0, 0);
      do_run(-1, "after_rst");
      check_run("after_rst", 1, 0, 0, 0);

      // Randomized faults against the reference model
      for (int i = 0; i < 6; i++) begin
         string tag;
         tag = $sformatf("rnd%0d", i);
         f_kind = int'($urandom_range(3, 0));
         f_addr = int'($urandom_range(WORDS - 1, 0));
         f_bit  = int'($urandom_range(DATA_W - 1, 0));
         march_model(f_kind, f_addr, f_bit);
         do_run(int'($urandom_range(OPS - 1, 1)), tag);
         check_run(tag, (m_errs == 0) ? 1 : 0, m_errs, m_faddr, m_fsyn);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
